// File: rtl/regfile_mp.sv
// Multi-port register file with load scoreboard; top index is the PC (reads return R15).
// Optional `REGFILE_BYPASS_EN forwards same-cycle write data and load-completion busy state to readers.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 16,
  parameter int unsigned NRD    = 3,
  parameter int unsigned ADDR_W = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WE_A,
  input  logic [ADDR_W-1:0]       WA_A,
  input  logic [DATA_W-1:0]       WD_A,
  input  logic                    WE_B,
  input  logic [ADDR_W-1:0]       WA_B,
  input  logic [DATA_W-1:0]       WD_B,
  input  logic                    MARK,
  input  logic [ADDR_W-1:0]       MARK_REG,
  input  logic [DATA_W-1:0]       R15,
  input  logic [NRD*ADDR_W-1:0]   RA,
  output logic [NRD*DATA_W-1:0]   RD,
  output logic [NRD-1:0]          BUSY,
  output logic                    ANY_BUSY
);

  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREGS - 1);

  // The PC slot exists in the arrays only to keep indexing simple; it is never written.
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // Port A is assigned last so it wins a same-register collision.
      if (WE_B && (WA_B < PC_IDX)) regs[WA_B] <= WD_B;
      if (WE_A && (WA_A < PC_IDX)) regs[WA_A] <= WD_A;
      // MARK is applied after the WE_B clear so a simultaneous set wins.
      if (WE_B && (WA_B < PC_IDX))         busy_q[WA_B]     <= 1'b0;
      if (MARK && (MARK_REG < PC_IDX))     busy_q[MARK_REG] <= 1'b1;
    end
  end

  always_comb begin
    RD   = '0;
    BUSY = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              b;
      a = RA[i*ADDR_W +: ADDR_W];
      d = '0;
      b = 1'b0;
      if (a == PC_IDX) begin
        d = R15;
      end else if (a < PC_IDX) begin
        d = regs[a];
        b = busy_q[a];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is suppressed during reset so readers see the cleared state.
        if (!rst) begin
          if (WE_A && (WA_A == a))      d = WD_A;
          else if (WE_B && (WA_B == a)) d = WD_B;
          if (WE_B && (WA_B == a) && !(MARK && (MARK_REG == a))) b = 1'b0;
        end
`endif
      end
      RD[i*DATA_W +: DATA_W] = d;
      BUSY[i]                = b;
    end
  end

  assign ANY_BUSY = |busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters (32-bit, 16 regs, 3 read ports).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic        WE_A, WE_B, MARK;
  logic [3:0]  WA_A, WA_B, MARK_REG;
  logic [31:0] WD_A, WD_B, R15;
  logic [11:0] RA;
  logic [95:0] RD;
  logic [2:0]  BUSY;
  logic        ANY_BUSY;

  int n_vec = 0;
  int n_bad = 0;

  regfile_mp #(.DATA_W(32), .NREGS(16), .NRD(3)) dut (
    .clk(clk), .rst(rst),
    .WE_A(WE_A), .WA_A(WA_A), .WD_A(WD_A),
    .WE_B(WE_B), .WA_B(WA_B), .WD_B(WD_B),
    .MARK(MARK), .MARK_REG(MARK_REG),
    .R15(R15), .RA(RA), .RD(RD), .BUSY(BUSY), .ANY_BUSY(ANY_BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd_port(input int p);
    return RD[p*32 +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    WE_A = 1'b0; WA_A = '0; WD_A = '0;
    WE_B = 1'b0; WA_B = '0; WD_B = '0;
    MARK = 1'b0; MARK_REG = '0;
  endtask

  task automatic read_all(input logic [3:0] a);
    RA = {a, a, a};
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    R15 = 32'h0000_1008;
    RA  = {4'd15, 4'd3, 4'd0};
    #2;
    n_vec++; if (rd_port(0) !== 32'h0) begin n_bad++; $display("FAIL reset_rd0: got %h want %h", rd_port(0), 32'h0); end
    n_vec++; if (rd_port(1) !== 32'h0) begin n_bad++; $display("FAIL reset_rd1: got %h want %h", rd_port(1), 32'h0); end
    n_vec++; if (rd_port(2) !== 32'h1008) begin n_bad++; $display("FAIL reset_pc: got %h want %h", rd_port(2), 32'h1008); end
    n_vec++; if (BUSY !== 3'b000) begin n_bad++; $display("FAIL reset_busy: got %b want %b", BUSY, 3'b000); end
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_any: got %b want %b", ANY_BUSY, 1'b0); end
    // Writes and MARK held during reset must be ignored.
    WE_A = 1'b1; WA_A = 4'd1; WD_A = 32'h55;
    MARK = 1'b1; MARK_REG = 4'd1;
    tick();
    idle_inputs();
    rst = 1'b0;
    read_all(4'd1);
    n_vec++; if (rd_port(0) !== 32'h0) begin n_bad++; $display("FAIL reset_wr_ignored: got %h want %h", rd_port(0), 32'h0); end
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_mark_ignored: got %b want %b", ANY_BUSY, 1'b0); end
  endtask

  task automatic test_write_read;
    WE_A = 1'b1; WA_A = 4'd3; WD_A = 32'h0000_00A5;
    tick();
    idle_inputs();
    read_all(4'd3);
    for (int p = 0; p < 3; p++) begin
      n_vec++; if (rd_port(p) !== 32'hA5) begin n_bad++; $display("FAIL wr_r3_port%0d: got %h want %h", p, rd_port(p), 32'hA5); end
    end
    n_vec++; if (BUSY !== 3'b000) begin n_bad++; $display("FAIL wr_r3_busy: got %b want %b", BUSY, 3'b000); end
  endtask

  task automatic test_port_priority;
    WE_A = 1'b1; WA_A = 4'd4; WD_A = 32'h11;
    WE_B = 1'b1; WA_B = 4'd4; WD_B = 32'h22;
    tick();
    idle_inputs();
    read_all(4'd4);
    n_vec++; if (rd_port(1) !== 32'h11) begin n_bad++; $display("FAIL a_wins_r4: got %h want %h", rd_port(1), 32'h11); end
    // Distinct destinations: both writes land.
    WE_A = 1'b1; WA_A = 4'd8; WD_A = 32'h33;
    WE_B = 1'b1; WA_B = 4'd9; WD_B = 32'h44;
    tick();
    idle_inputs();
    RA = {4'd9, 4'd8, 4'd4};
    #1;
    n_vec++; if (rd_port(0) !== 32'h11) begin n_bad++; $display("FAIL dual_r4: got %h want %h", rd_port(0), 32'h11); end
    n_vec++; if (rd_port(1) !== 32'h33) begin n_bad++; $display("FAIL dual_r8: got %h want %h", rd_port(1), 32'h33); end
    n_vec++; if (rd_port(2) !== 32'h44) begin n_bad++; $display("FAIL dual_r9: got %h want %h", rd_port(2), 32'h44); end
  endtask

  task automatic test_scoreboard;
    MARK = 1'b1; MARK_REG = 4'd5;
    tick();
    idle_inputs();
    RA = {4'd5, 4'd5, 4'd3};
    #1;
    n_vec++; if (BUSY !== 3'b110) begin n_bad++; $display("FAIL mark_r5_busy: got %b want %b", BUSY, 3'b110); end
    n_vec++; if (ANY_BUSY !== 1'b1) begin n_bad++; $display("FAIL mark_r5_any: got %b want %b", ANY_BUSY, 1'b1); end
    // ALU write to a pending register updates data but leaves it busy.
    WE_A = 1'b1; WA_A = 4'd5; WD_A = 32'h55;
    tick();
    idle_inputs();
    read_all(4'd5);
    n_vec++; if (rd_port(0) !== 32'h55) begin n_bad++; $display("FAIL wea_busy_data: got %h want %h", rd_port(0), 32'h55); end
    n_vec++; if (BUSY !== 3'b111) begin n_bad++; $display("FAIL wea_keeps_busy: got %b want %b", BUSY, 3'b111); end
    WE_B = 1'b1; WA_B = 4'd5; WD_B = 32'h77;
    tick();
    idle_inputs();
    read_all(4'd5);
    n_vec++; if (BUSY !== 3'b000) begin n_bad++; $display("FAIL web_clears_busy: got %b want %b", BUSY, 3'b000); end
    n_vec++; if (rd_port(2) !== 32'h77) begin n_bad++; $display("FAIL web_r5_data: got %h want %h", rd_port(2), 32'h77); end
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL web_any_clear: got %b want %b", ANY_BUSY, 1'b0); end
  endtask

  task automatic test_mark_vs_wb;
    MARK = 1'b1; MARK_REG = 4'd6;
    WE_B = 1'b1; WA_B = 4'd6; WD_B = 32'h66;
    tick();
    idle_inputs();
    read_all(4'd6);
    n_vec++; if (BUSY !== 3'b111) begin n_bad++; $display("FAIL mark_wins_busy: got %b want %b", BUSY, 3'b111); end
    n_vec++; if (rd_port(0) !== 32'h66) begin n_bad++; $display("FAIL mark_wins_data: got %h want %h", rd_port(0), 32'h66); end
    WE_B = 1'b1; WA_B = 4'd6; WD_B = 32'h0;
    tick();
    idle_inputs();
    #1;
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL r6_release: got %b want %b", ANY_BUSY, 1'b0); end
  endtask

  task automatic test_pc;
    R15 = 32'h0000_1008;
    WE_A = 1'b1; WA_A = 4'd15; WD_A = 32'hFFFF_FFFF;
    WE_B = 1'b1; WA_B = 4'd15; WD_B = 32'hEEEE_EEEE;
    MARK = 1'b1; MARK_REG = 4'd15;
    read_all(4'd15);
    n_vec++; if (rd_port(0) !== 32'h1008) begin n_bad++; $display("FAIL pc_same_cycle: got %h want %h", rd_port(0), 32'h1008); end
    tick();
    idle_inputs();
    read_all(4'd15);
    n_vec++; if (rd_port(1) !== 32'h1008) begin n_bad++; $display("FAIL pc_after_wr: got %h want %h", rd_port(1), 32'h1008); end
    n_vec++; if (BUSY !== 3'b000) begin n_bad++; $display("FAIL pc_busy: got %b want %b", BUSY, 3'b000); end
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL pc_mark_ignored: got %b want %b", ANY_BUSY, 1'b0); end
    R15 = 32'h0000_2000;
    #1;
    n_vec++; if (rd_port(2) !== 32'h2000) begin n_bad++; $display("FAIL pc_follows_r15: got %h want %h", rd_port(2), 32'h2000); end
    RA = {4'd3, 4'd3, 4'd3};
    #1;
    n_vec++; if (rd_port(0) !== 32'hA5) begin n_bad++; $display("FAIL pc_r3_intact: got %h want %h", rd_port(0), 32'hA5); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_d;
    logic [2:0]  exp_b;
    WE_A = 1'b1; WA_A = 4'd7; WD_A = 32'h07;
    MARK = 1'b1; MARK_REG = 4'd10;
    tick();
    idle_inputs();
    WE_A = 1'b1; WA_A = 4'd7; WD_A = 32'hDEAD_BEEF;
    read_all(4'd7);
`ifdef REGFILE_BYPASS_EN
    exp_d = 32'hDEAD_BEEF;
`else
    exp_d = 32'h07;
`endif
    n_vec++; if (rd_port(0) !== exp_d) begin n_bad++; $display("FAIL r7_same_cycle: got %h want %h", rd_port(0), exp_d); end
    tick();
    idle_inputs();
    read_all(4'd7);
    n_vec++; if (rd_port(2) !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL r7_next_cycle: got %h want %h", rd_port(2), 32'hDEAD_BEEF); end
    // Load completion on a pending register, observed before the edge.
    WE_B = 1'b1; WA_B = 4'd10; WD_B = 32'hAB;
    RA = {4'd10, 4'd10, 4'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_b = 3'b000;
    exp_d = 32'hAB;
`else
    exp_b = 3'b110;
    exp_d = 32'h0;
`endif
    n_vec++; if (BUSY !== exp_b) begin n_bad++; $display("FAIL r10_busy_bypass: got %b want %b", BUSY, exp_b); end
    n_vec++; if (rd_port(1) !== exp_d) begin n_bad++; $display("FAIL r10_data_bypass: got %h want %h", rd_port(1), exp_d); end
    n_vec++; if (ANY_BUSY !== 1'b1) begin n_bad++; $display("FAIL r10_any_registered: got %b want %b", ANY_BUSY, 1'b1); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL r10_cleared: got %b want %b", ANY_BUSY, 1'b0); end
  endtask

  task automatic test_reset_mid_write;
    MARK = 1'b1; MARK_REG = 4'd11;
    tick();
    idle_inputs();
    WE_A = 1'b1; WA_A = 4'd7; WD_A = 32'h1234_5678;
    RA = {4'd11, 4'd3, 4'd7};
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (rd_port(0) !== 32'h0) begin n_bad++; $display("FAIL rst_async_r7: got %h want %h", rd_port(0), 32'h0); end
    n_vec++; if (rd_port(1) !== 32'h0) begin n_bad++; $display("FAIL rst_async_r3: got %h want %h", rd_port(1), 32'h0); end
    n_vec++; if (ANY_BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_async_any: got %b want %b", ANY_BUSY, 1'b0); end
    tick();
    rst = 1'b0;
    idle_inputs();
    read_all(4'd7);
    n_vec++; if (rd_port(0) !== 32'h0) begin n_bad++; $display("FAIL rst_r7_zero: got %h want %h", rd_port(0), 32'h0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_port_priority();
    test_scoreboard();
    test_mark_vs_wb();
    test_pc();
    test_bypass();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NREGS, default 16, architectural register count; index NREGS-1 is the PC.
REQ-003 SHALL have parameter NRD, default 3, number of read ports; legal range 1..4.
REQ-004 SHALL use ADDR_W = clog2(NREGS) for every register index.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port WE_A  input  1  ALU write-back enable.
REQ-008 SHALL have port WA_A  input  ADDR_W  ALU write-back destination.
REQ-009 SHALL have port WD_A  input  DATA_W  ALU write-back data.
REQ-010 SHALL have port WE_B  input  1  load write-back enable.
REQ-011 SHALL have port WA_B  input  ADDR_W  load write-back destination.
REQ-012 SHALL have port WD_B  input  DATA_W  load write-back data.
REQ-013 SHALL have port MARK  input  1  load issued; marks a destination pending.
REQ-014 SHALL have port MARK_REG  input  ADDR_W  destination being marked pending.
REQ-015 SHALL have port R15  input  DATA_W  current PC+8 value.
REQ-016 SHALL have port RA  input  NRD*ADDR_W  packed read addresses; port i at slice i.
REQ-017 SHALL have port RD  output  NRD*DATA_W  packed read data.
REQ-018 SHALL have port BUSY  output  NRD  per-port pending flag for the addressed register.
REQ-019 SHALL have port ANY_BUSY  output  1  OR of all scoreboard bits.

Function
REQ-020 SHALL store NREGS-1 registers; reads of index NREGS-1 return R15 with BUSY=0.
REQ-021 SHALL ignore writes and MARK targeting index NREGS-1.
REQ-022 SHALL write WD_A/WD_B on the rising edge when the respective enable is high.
REQ-023 SHALL, when WE_A and WE_B target the same register in one cycle, store WD_A (port A wins).
REQ-024 SHALL hold one busy bit per register: set on edge when MARK targets it, cleared on edge when WE_B targets it.
REQ-025 SHALL give set priority when MARK and WE_B target the same register in one cycle (bit stays 1).
REQ-026 SHALL NOT clear a busy bit on WE_A; WE_A to a busy register updates data only.
REQ-027 SHALL drive RD and BUSY combinationally from RA, stored state and, per REQ-031, same-cycle writes.
REQ-028 SHALL drive ANY_BUSY from registered busy bits only (no bypass).
REQ-029 SHALL produce identical results on all read ports addressing the same register.

Reset
REQ-030 SHALL, while rst is high, clear all registers and busy bits to 0 immediately; RD reads 0 (R15 for PC), BUSY=0, ANY_BUSY=0; writes and MARK ignored.

Configuration
REQ-031 SHALL, with REGFILE_BYPASS_EN defined, forward same-cycle write data to any read port whose address matches (port A over port B) and report BUSY=0 for a port whose address matches an active WE_B and not an active MARK.
REQ-032 SHALL, without REGFILE_BYPASS_EN, return only stored values; a write becomes readable the cycle after its edge, and BUSY reflects registered bits only.

Verification
REQ-033 SHALL cover: reset, write R3=0x0000_00A5 via port A, read next cycle on all ports -> 0xA5 everywhere.
REQ-034 SHALL cover: WE_A and WE_B to R4 with 0x11/0x22 same cycle -> R4=0x11 after edge.
REQ-035 SHALL cover: MARK R5, next cycle read R5 -> BUSY=1, ANY_BUSY=1; WE_B R5=0x77 -> after edge BUSY=0, RD=0x77.
REQ-036 SHALL cover: MARK R6 and WE_B R6 same cycle -> busy bit remains 1.
REQ-037 SHALL cover: R15=0x0000_1008, RA=15, WE_A to 15 -> RD=0x1008, stored state unchanged, BUSY=0.
REQ-038 SHALL cover: with REGFILE_BYPASS_EN, WE_A R7=0xDEAD_BEEF reading R7 same cycle -> RD=0xDEADBEEF; without it -> old value; rst asserted mid-write -> R7=0.
